bench_sweep_ctrl: RTL

Exhaustive-stimulus sequencer for small trojan-detection benchmark DUTs. On a start request it drives every input pattern 0 … 2^N_WIDTH−1 into the DUT in ascending order. After a programmable settle time it samples the DUT's single-bit output for each pattern and assembles the results into a truth-table signature. It then compares that signature against a golden value and reports a pass/fail flag. The block sits between the bench top level and the DUT, replacing hand-written per-pattern stimulus.

---
 rtl/bench_sweep_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bench_sweep_ctrl.sv
// Exhaustive stimulus sequencer: drives every N_WIDTH-bit pattern into a DUT, samples its
// single-bit output after SETTLE cycles, builds a truth-table signature and compares to golden.
`timescale 1ns/1ps
module bench_sweep_ctrl #(
  parameter int unsigned N_WIDTH = 2,
  parameter int unsigned SETTLE  = 1
) (
  input  logic                     CK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [(1<<N_WIDTH)-1:0]  golden,
  input  logic                     dut_out,
  output logic [N_WIDTH-1:0]       dut_in,
  output logic                     busy,
  output logic                     sample_valid,
  output logic [N_WIDTH-1:0]       sample_pattern,
  output logic                     sample_value,
  output logic [(1<<N_WIDTH)-1:0]  signature,
  output logic                     done,
  output logic                     mismatch
);

  localparam int unsigned NPat    = 1 << N_WIDTH;
  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);
  localparam logic [N_WIDTH-1:0] PatLast    = N_WIDTH'(NPat - 1);
  localparam logic [N_WIDTH-1:0] PatOne     = N_WIDTH'(1);
  localparam logic [SettleW-1:0] SettleOne  = SettleW'(1);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_WIDTH-1:0]  pattern_q, pattern_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [N_WIDTH-1:0]  dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                sv_q, sv_d;
  logic [N_WIDTH-1:0]  sp_q, sp_d;
  logic                sval_q, sval_d;
  logic [NPat-1:0]     sig_q, sig_d, sig_next;
  logic [NPat-1:0]     golden_q, golden_d;
  logic                done_q, done_d;
  logic                mismatch_q, mismatch_d;

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    settle_d   = settle_q;
    dut_in_d   = dut_in_q;
    sp_d       = sp_q;
    sval_d     = sval_q;
    sig_d      = sig_q;
    golden_d   = golden_q;
    mismatch_d = mismatch_q;
    sv_d       = 1'b0;
    done_d     = 1'b0;
    sig_next   = sig_q;
    sig_next[pattern_q] = dut_out;

    unique case (state_q)
      StIdle: begin
        // start beats abort here; abort is meaningless outside a sweep
        if (start) begin
          state_d    = StWait;
          pattern_d  = '0;
          dut_in_d   = '0;
          settle_d   = '0;
          sig_d      = '0;
          mismatch_d = 1'b0;
          golden_d   = golden;
        end
      end
      StWait: begin
        if (abort) begin
          state_d  = StIdle;
          dut_in_d = '0;
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + SettleOne;
        end
      end
      StSample: begin
        if (abort) begin
          state_d  = StIdle;
          dut_in_d = '0;
        end else begin
          sig_d  = sig_next;
          sv_d   = 1'b1;
          sp_d   = pattern_q;
          sval_d = dut_out;
          // explicit last-pattern test keeps the counter from ever wrapping
          if (pattern_q == PatLast) begin
            state_d    = StDone;
            done_d     = 1'b1;
            mismatch_d = (sig_next != golden_q);
          end else begin
            pattern_d = pattern_q + PatOne;
            dut_in_d  = pattern_q + PatOne;
            state_d   = StWait;
          end
        end
      end
      StDone: begin
        state_d  = StIdle;
        dut_in_d = '0;
      end
      default: begin
        state_d  = StIdle;
        dut_in_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q    <= StIdle;
      pattern_q  <= '0;
      settle_q   <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      sv_q       <= 1'b0;
      sp_q       <= '0;
      sval_q     <= 1'b0;
      sig_q      <= '0;
      golden_q   <= '0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      settle_q   <= settle_d;
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      sv_q       <= sv_d;
      sp_q       <= sp_d;
      sval_q     <= sval_d;
      sig_q      <= sig_d;
      golden_q   <= golden_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign sample_valid   = sv_q;
  assign sample_pattern = sp_q;
  assign sample_value   = sval_q;
  assign signature      = sig_q;
  assign done           = done_q;
  assign mismatch       = mismatch_q;

endmodule
